// File: rtl/pipeline_run_monitor.sv
// -----------------------------------------------------------------------------
// pipeline_run_monitor
//
// Run controller that sits between the bench and a pipelined core. It holds
// the core in reset for RST_HOLD cycles after RESET drops, then lets it run.
// While running it counts cycles and retired instructions and watches for the
// end of the program:
//   - a store to END_ADDR (data PASS_CODE = pass, any other data = fail),
//   - the PC stuck for HANG_CYCLES retiring cycles (a "j ." halt loop),
//   - a watchdog after TIMEOUT_CYC cycles.
// Once the run has ended, DONE/STATUS hold until RESET, the counters freeze,
// and the core stays out of reset so its state can be inspected.
//
// Ports
//   CLK          in   1       clock, rising edge
//   RESET        in   1       asynchronous active-high reset
//   PC           in   ADDR_W  core fetch PC
//   RETIRE       in   1       one instruction retired this cycle
//   MEM_WE       in   1       data-memory write enable
//   MEM_ADDR     in   ADDR_W  data-memory address
//   MEM_WDATA    in   DATA_W  data-memory write data
//   CORE_RESET_N out  1       registered active-low reset to the core
//   RUNNING      out  1       core is in the RUN phase
//   DONE         out  1       sticky, run finished for any reason
//   STATUS       out  2       0 none, 1 pass, 2 fail, 3 timeout/hang
//   CYCLES       out  CNT_W   saturating count of cycles spent in RUN
//   RETIRED      out  CNT_W   saturating count of RETIRE pulses in RUN
//   END_DATA     out  DATA_W  data of the store that ended the run
// -----------------------------------------------------------------------------
module pipeline_run_monitor #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        CNT_W       = 32,
  parameter int unsigned        RST_HOLD    = 4,
  parameter logic [ADDR_W-1:0]  END_ADDR    = ADDR_W'(32'h0000_0FFC),
  parameter logic [DATA_W-1:0]  PASS_CODE   = DATA_W'(1),
  parameter int unsigned        HANG_CYCLES = 16,
  parameter int unsigned        TIMEOUT_CYC = 2500
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC,
  input  logic              RETIRE,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic              CORE_RESET_N,
  output logic              RUNNING,
  output logic              DONE,
  output logic [1:0]        STATUS,
  output logic [CNT_W-1:0]  CYCLES,
  output logic [CNT_W-1:0]  RETIRED,
  output logic [DATA_W-1:0] END_DATA
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned HANG_W = $clog2(HANG_CYCLES + 1);
  // Watchdog compare is done in a wider domain so a TIMEOUT_CYC that does not
  // fit in CNT_W bits simply never fires instead of aliasing to a small value.
  localparam int unsigned WIDE_W = CNT_W + 32;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  state_e              state_q,        state_d;
  logic [HOLD_W-1:0]   hold_cnt_q,     hold_cnt_d;
  logic                core_reset_n_q, core_reset_n_d;
  logic                done_q,         done_d;
  status_e             status_q,       status_d;
  logic [CNT_W-1:0]    cycles_q,       cycles_d;
  logic [CNT_W-1:0]    retired_q,      retired_d;
  logic [DATA_W-1:0]   end_data_q,     end_data_d;
  logic [HANG_W-1:0]   hang_cnt_q,     hang_cnt_d;
  logic [ADDR_W-1:0]   last_pc_q,      last_pc_d;

  logic [CNT_W-1:0]    cycles_inc;
  logic [CNT_W-1:0]    retired_inc;
  logic [WIDE_W-1:0]   cycles_wide;
  logic                end_store;
  logic                pc_same;
  logic                hang_hit;
  logic                watchdog_hit;

  // Saturating increments: hold at all-ones rather than wrap.
  assign cycles_inc   = (&cycles_q)  ? cycles_q  : cycles_q  + CNT_W'(1);
  assign retired_inc  = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
  assign cycles_wide  = WIDE_W'(cycles_inc);

  assign end_store    = MEM_WE && (MEM_ADDR == END_ADDR);
  assign pc_same      = (PC == last_pc_q);
  // The counter is about to reach HANG_CYCLES on this edge.
  assign hang_hit     = pc_same && RETIRE && (hang_cnt_q == HANG_W'(HANG_CYCLES - 1));
  // The cycle being counted now is the TIMEOUT_CYC-th one in RUN.
  assign watchdog_hit = (cycles_wide >= WIDE_W'(TIMEOUT_CYC));

  always_comb begin
    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    core_reset_n_d = core_reset_n_q;
    done_d         = done_q;
    status_d       = status_q;
    cycles_d       = cycles_q;
    retired_d      = retired_q;
    end_data_d     = end_data_q;
    hang_cnt_d     = hang_cnt_q;
    last_pc_d      = last_pc_q;

    unique case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d        = S_RUN;
          core_reset_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      S_RUN: begin
        // The cycle on which the run ends is still counted.
        cycles_d  = cycles_inc;
        retired_d = RETIRE ? retired_inc : retired_q;
        last_pc_d = PC;

        if (!pc_same) begin
          hang_cnt_d = '0;
        end else if (RETIRE) begin
          hang_cnt_d = hang_cnt_q + HANG_W'(1);
        end

        // Priority: end store, then hang, then watchdog.
        if (end_store) begin
          end_data_d = MEM_WDATA;
          done_d     = 1'b1;
          if (MEM_WDATA == PASS_CODE) begin
            state_d  = S_PASS;
            status_d = ST_PASS;
          end else begin
            state_d  = S_FAIL;
            status_d = ST_FAIL;
          end
        end else if (hang_hit || watchdog_hit) begin
          state_d  = S_TIMEOUT;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
        end
      end

      // End states are terminal: everything holds until RESET.
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_HOLD;
      hold_cnt_q     <= '0;
      core_reset_n_q <= 1'b0;
      done_q         <= 1'b0;
      status_q       <= ST_NONE;
      cycles_q       <= '0;
      retired_q      <= '0;
      end_data_q     <= '0;
      hang_cnt_q     <= '0;
      last_pc_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      core_reset_n_q <= core_reset_n_d;
      done_q         <= done_d;
      status_q       <= status_d;
      cycles_q       <= cycles_d;
      retired_q      <= retired_d;
      end_data_q     <= end_data_d;
      hang_cnt_q     <= hang_cnt_d;
      last_pc_q      <= last_pc_d;
    end
  end

  assign CORE_RESET_N = core_reset_n_q;
  assign RUNNING      = (state_q == S_RUN);
  assign DONE         = done_q;
  assign STATUS       = status_q;
  assign CYCLES       = cycles_q;
  assign RETIRED      = retired_q;
  assign END_DATA     = end_data_q;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_monitor
//
// Scoreboard bench. The stimulus process builds a per-cycle trace for each
// run, computes the expected end of run from the trace with a simple model,
// pushes it into a queue and drives the trace. A monitor process pops the
// queue whenever DONE rises and compares. A second instance with CNT_W=4
// exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipeline_run_monitor;

  localparam int          RST_HOLD = 4;
  localparam int          HANG     = 16;
  localparam int          TMO      = 2500;
  localparam logic [31:0] END_ADDR = 32'h0000_0FFC;
  localparam int          MAXT     = 2600;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic [31:0] PC;
  logic        RETIRE;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        CORE_RESET_N;
  logic        RUNNING;
  logic        DONE;
  logic [1:0]  STATUS;
  logic [31:0] CYCLES;
  logic [31:0] RETIRED;
  logic [31:0] END_DATA;

  pipeline_run_monitor dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .RETIRE(RETIRE), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .CORE_RESET_N(CORE_RESET_N),
    .RUNNING(RUNNING), .DONE(DONE), .STATUS(STATUS), .CYCLES(CYCLES),
    .RETIRED(RETIRED), .END_DATA(END_DATA)
  );

  // Narrow-counter instance.
  logic        rst4 = 1'b1;
  logic [31:0] pc4 = '0;
  logic        ret4 = 1'b0;
  logic        we4 = 1'b0;
  logic [31:0] addr4 = '0;
  logic [31:0] wdata4 = '0;
  logic        core4, run4, done4;
  logic [1:0]  status4;
  logic [3:0]  cycles4, retired4;
  logic [31:0] end4;

  pipeline_run_monitor #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(rst4), .PC(pc4), .RETIRE(ret4), .MEM_WE(we4),
    .MEM_ADDR(addr4), .MEM_WDATA(wdata4), .CORE_RESET_N(core4),
    .RUNNING(run4), .DONE(done4), .STATUS(status4), .CYCLES(cycles4),
    .RETIRED(retired4), .END_DATA(end4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        retire;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  typedef struct {
    int          run_cyc;
    logic [1:0]  status;
    logic [31:0] cycles;
    logic [31:0] retired;
    logic [31:0] end_data;
  } exp_t;

  cyc_t tr[MAXT];
  int   tr_len;
  exp_t sb_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: walk the trace, find the first cycle that ends the run.
  // ---------------------------------------------------------------------------
  task automatic run_model(output exp_t e, output int k_end);
    int          ret_sum;
    int          repeats;   // retiring cycles seen at the current PC since it last changed
    logic [31:0] prev_pc;
    bit          ended;
    ret_sum    = 0;
    repeats    = 0;
    prev_pc    = '0;
    k_end      = -1;
    e.run_cyc  = 0;
    e.status   = 2'd0;
    e.cycles   = '0;
    e.retired  = '0;
    e.end_data = '0;
    for (int k = 0; k < tr_len; k++) begin
      ended = 1'b0;
      if (tr[k].retire) ret_sum++;
      if (tr[k].pc != prev_pc) repeats = 0;
      else if (tr[k].retire)   repeats++;
      prev_pc = tr[k].pc;
      if (tr[k].we && tr[k].addr == END_ADDR) begin
        e.status   = (tr[k].wdata == 32'd1) ? 2'd1 : 2'd2;
        e.end_data = tr[k].wdata;
        ended      = 1'b1;
      end else if (repeats == HANG || k + 1 == TMO) begin
        e.status = 2'd3;
        ended    = 1'b1;
      end
      if (ended) begin
        e.run_cyc = k + 1;
        e.cycles  = 32'(k + 1);
        e.retired = 32'(ret_sum);
        k_end     = k;
        return;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Trace builders
  // ---------------------------------------------------------------------------
  task automatic gen_linear(input int len);
    tr_len = len;
    for (int k = 0; k < len; k++) begin
      tr[k].pc     = 32'h1000 + 32'(k) * 4;
      tr[k].retire = ($urandom_range(0, 1) == 1);
      tr[k].we     = 1'b0;
      tr[k].addr   = '0;
      tr[k].wdata  = '0;
    end
  endtask

  task automatic put_store(input int k, input logic [31:0] a, input logic [31:0] d);
    tr[k].we    = 1'b1;
    tr[k].addr  = a;
    tr[k].wdata = d;
  endtask

  task automatic gen_random(input int len);
    logic [31:0] pc;
    logic [31:0] a;
    tr_len = len;
    pc     = 32'h100;
    for (int k = 0; k < len; k++) begin
      // PC often stays put so hang detection is exercised now and then.
      if ($urandom_range(0, 9) < 3) pc = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      tr[k].pc     = pc;
      tr[k].retire = ($urandom_range(0, 3) != 0);
      tr[k].we     = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       a = END_ADDR + 32'd4;
        1:       a = END_ADDR - 32'd4;
        2:       a = 32'h200;
        default: a = $urandom;
      endcase
      if (a == END_ADDR) a = a ^ 32'h4;
      tr[k].addr  = a;
      tr[k].wdata = $urandom;
    end
    put_store(len - 1, END_ADDR, ($urandom_range(0, 1) == 1) ? 32'd1 : ($urandom | 32'h2));
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drive_junk();
    PC        = $urandom;
    RETIRE    = 1'b1;
    MEM_WE    = 1'b1;
    MEM_ADDR  = END_ADDR;
    MEM_WDATA = $urandom | 32'h2;
  endtask

  task automatic drive_trace(input int k);
    if (k < tr_len) begin
      PC        = tr[k].pc;
      RETIRE    = tr[k].retire;
      MEM_WE    = tr[k].we;
      MEM_ADDR  = tr[k].addr;
      MEM_WDATA = tr[k].wdata;
    end else begin
      drive_junk();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset_n"}, 64'(CORE_RESET_N), 64'd0);
    check({tag, "_running"},      64'(RUNNING),      64'd0);
    check({tag, "_done"},         64'(DONE),         64'd0);
    check({tag, "_status"},       64'(STATUS),       64'd0);
    check({tag, "_cycles"},       64'(CYCLES),       64'd0);
    check({tag, "_retired"},      64'(RETIRED),      64'd0);
    check({tag, "_end_data"},     64'(END_DATA),     64'd0);
  endtask

  // One complete run: reset, hold sequence, trace, then end-state checks.
  task automatic run_scenario(input string name, input bit mid_reset, input int reset_at);
    exp_t e;
    int   k_end;
    int   last;
    RESET = 1'b1;
    drive_junk();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values({name, "_in_reset"});
    RESET = 1'b0;

    for (int ed = 1; ed <= RST_HOLD; ed++) begin
      @(posedge CLK);
      #1;
      check({name, "_core_reset_n_hold"}, 64'(CORE_RESET_N), 64'(ed == RST_HOLD));
      if (ed < RST_HOLD) begin
        check({name, "_cycles_hold"}, 64'(CYCLES), 64'd0);
        drive_junk();
      end
    end
    check({name, "_running_start"}, 64'(RUNNING), 64'd1);
    check({name, "_retired_start"}, 64'(RETIRED), 64'd0);

    run_model(e, k_end);
    if (!mid_reset && k_end >= 0) sb_q.push_back(e);
    if (mid_reset)       last = reset_at;
    else if (k_end < 0)  last = tr_len - 1;
    else                 last = k_end;

    for (int k = 0; k <= last + 4; k++) begin
      if (k > 0) begin
        @(posedge CLK);
        #1;
      end
      if (mid_reset && k == reset_at) begin
        check({name, "_cycles_before_reset"}, 64'(CYCLES), 64'(reset_at));
        drive_trace(k);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_values({name, "_mid_run"});
        return;
      end
      drive_trace(k);
    end

    // The monitor must have consumed this run's expectation by now.
    check({name, "_scoreboard_drained"}, 64'(sb_q.size()), 64'd0);
    if (sb_q.size() != 0) sb_q.delete();

    if (k_end >= 0) begin
      check({name, "_frozen_cycles"},   64'(CYCLES),       64'(e.cycles));
      check({name, "_frozen_retired"},  64'(RETIRED),      64'(e.retired));
      check({name, "_frozen_status"},   64'(STATUS),       64'(e.status));
      check({name, "_frozen_end_data"}, 64'(END_DATA),     64'(e.end_data));
      check({name, "_frozen_done"},     64'(DONE),         64'd1);
      check({name, "_frozen_running"},  64'(RUNNING),      64'd0);
      check({name, "_core_stays_up"},   64'(CORE_RESET_N), 64'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares whenever DONE rises.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    int   run_cyc;
    logic prev_done;
    exp_t e;
    run_cyc   = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (CORE_RESET_N !== 1'b1) run_cyc = 0;
      else if (DONE !== 1'b1)    run_cyc++;
      if (DONE === 1'b1 && prev_done !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE=1 after %0d run cycles, expected no end", run_cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 64'(run_cyc),  64'(e.run_cyc));
          check("status",     64'(STATUS),   64'(e.status));
          check("cycles",     64'(CYCLES),   64'(e.cycles));
          check("retired",    64'(RETIRED),  64'(e.retired));
          check("end_data",   64'(END_DATA), 64'(e.end_data));
          check("running",    64'(RUNNING),  64'd0);
        end
      end
      prev_done = DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    RESET = 1'b1;
    drive_junk();

    // Pass store at run cycle 20.
    gen_linear(21);
    put_store(20, END_ADDR, 32'd1);
    run_scenario("pass20", 1'b0, 0);

    // Near-miss store of 1 is ignored; bad code ends the run as fail.
    gen_linear(13);
    put_store(5, END_ADDR + 32'd4, 32'd1);
    put_store(12, END_ADDR, 32'hDEAD);
    run_scenario("fail_dead", 1'b0, 0);

    // PC stuck at 0x40 while retiring.
    gen_linear(40);
    for (int k = 0; k < 40; k++) begin
      tr[k].pc     = 32'h40;
      tr[k].retire = 1'b1;
    end
    run_scenario("hang", 1'b0, 0);

    // PC changes at cycle 15, so the hang count restarts and the store wins.
    gen_linear(36);
    for (int k = 0; k < 36; k++) begin
      tr[k].retire = 1'b1;
      tr[k].pc     = (k < 15) ? 32'h40 : 32'h44 + 32'(k - 15) * 4;
    end
    put_store(35, END_ADDR, 32'd1);
    run_scenario("hang_broken", 1'b0, 0);

    // Watchdog with no end event.
    gen_linear(TMO + 10);
    run_scenario("watchdog", 1'b0, 0);

    // End store on the watchdog cycle wins.
    gen_linear(TMO + 10);
    put_store(TMO - 1, END_ADDR, 32'd1);
    run_scenario("store_vs_watchdog", 1'b0, 0);

    // Reset pulsed mid-run, then a normal run must follow.
    gen_linear(100);
    run_scenario("mid_reset", 1'b1, 50);
    gen_linear(9);
    put_store(8, END_ADDR, 32'd1);
    run_scenario("after_reset", 1'b0, 0);

    // Randomised runs.
    for (int i = 0; i < 10; i++) begin
      gen_random($urandom_range(5, 60));
      run_scenario($sformatf("rand%0d", i), 1'b0, 0);
    end

    // Narrow counters saturate at 15.
    rst4 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rst4 = 1'b0;
    repeat (RST_HOLD) @(posedge CLK);
    #1;
    check("cnt4_core_up", 64'(core4), 64'd1);
    for (int k = 0; k < 20; k++) begin
      pc4  = 32'h2000 + 32'(k) * 4;
      ret4 = 1'b1;
      @(posedge CLK);
      #1;
    end
    check("cnt4_retired_sat", 64'(retired4), 64'd15);
    check("cnt4_cycles_sat",  64'(cycles4),  64'd15);
    check("cnt4_not_done",    64'(done4),    64'd0);
    we4    = 1'b1;
    addr4  = END_ADDR;
    wdata4 = 32'd1;
    pc4    = 32'h3000;
    @(posedge CLK);
    #1;
    we4 = 1'b0;
    check("cnt4_done",        64'(done4),    64'd1);
    check("cnt4_status",      64'(status4),  64'd1);
    check("cnt4_retired_end", 64'(retired4), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_bound
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
